// File: rtl/btn_pkg.sv
// Shared types and default sizing for the button conditioner.
// No datapath: types and constants only.
// No flow control.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } btn_state_t;

    localparam int DEF_N_BTN           = 5;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_REPEAT_DELAY    = 2000;
    localparam int DEF_REPEAT_RATE     = 400;

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debounce FSM, auto-repeat timer.
// Latency: press/release registered SYNC_STAGES+DEBOUNCE_CYCLES cycles after a clean btn edge.
// No backpressure: pulses are single-cycle and never held off.
module btn_channel
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic rpt_en,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic rpt
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DLY_W  = $clog2(REPEAT_DELAY + 1);
    localparam int RATE_W = $clog2(REPEAT_RATE + 1);

    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DLY_W-1:0]  DLY_MAX  = DLY_W'(REPEAT_DELAY);
    localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(REPEAT_RATE);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;

    btn_state_t             state_q, state_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d, db_inc;
    logic                   commit_press, commit_rel;

    logic [DLY_W-1:0]       dly_q, dly_d, dly_inc;
    logic [RATE_W-1:0]      rate_q, rate_d, rate_inc;
    logic                   fire;

    assign synced   = sync_q[SYNC_STAGES-1];
    assign db_inc   = (db_cnt_q == DB_MAX) ? db_cnt_q : db_cnt_q + 1'b1;
    assign dly_inc  = dly_q + 1'b1;
    assign rate_inc = rate_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        db_cnt_d     = db_cnt_q;
        commit_press = 1'b0;
        commit_rel   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (synced) begin
                    state_d  = ST_PRESS_DB;
                    db_cnt_d = '0;
                end
            end
            ST_PRESS_DB: begin
                if (!synced) begin
                    state_d = ST_IDLE;
                end else if (db_inc == DB_MAX) begin
                    state_d      = ST_HELD;
                    commit_press = 1'b1;
                end else begin
                    db_cnt_d = db_inc;
                end
            end
            ST_HELD: begin
                if (!synced) begin
                    state_d  = ST_RELEASE_DB;
                    db_cnt_d = '0;
                end
            end
            ST_RELEASE_DB: begin
                if (synced) begin
                    state_d = ST_HELD;
                end else if (db_inc == DB_MAX) begin
                    state_d    = ST_IDLE;
                    commit_rel = 1'b1;
                end else begin
                    db_cnt_d = db_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Delay counter saturates at REPEAT_DELAY, then the rate counter paces later pulses.
    always_comb begin
        dly_d  = dly_q;
        rate_d = rate_q;
        fire   = 1'b0;
        if (commit_press) begin
            dly_d  = '0;
            rate_d = '0;
        end else if (level) begin
            if (dly_q != DLY_MAX) begin
                dly_d = dly_inc;
                fire  = (dly_inc == DLY_MAX);
            end else if (rate_inc == RATE_MAX) begin
                rate_d = '0;
                fire   = 1'b1;
            end else begin
                rate_d = rate_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q        <= '0;
            state_q       <= ST_IDLE;
            db_cnt_q      <= '0;
            dly_q         <= '0;
            rate_q        <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            rpt           <= 1'b0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], btn};
            state_q       <= state_d;
            db_cnt_q      <= db_cnt_d;
            dly_q         <= dly_d;
            rate_q        <= rate_d;
            level         <= (state_d == ST_HELD) || (state_d == ST_RELEASE_DB);
            press         <= commit_press;
            release_pulse <= commit_rel;
            rpt           <= fire & rpt_en & ~commit_rel;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// N_BTN independent debounced button channels with auto-repeat, plus an any-press flag.
// Latency: per-channel SYNC_STAGES+DEBOUNCE_CYCLES; any_press is combinational from press.
// No backpressure. The release output is named release_pulse since `release` is reserved.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    input  logic [N_BTN-1:0] rpt_en,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] rpt,
    output logic             any_press
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .btn          (btn[i]),
            .rpt_en       (rpt_en[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i]),
            .rpt          (rpt[i])
        );
    end

    assign any_press = |press;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random stimulus against a
// sample-history reference model (a level flips after DEBOUNCE+1 agreeing synced samples).
module tb_button_conditioner;

    localparam int N    = 5;
    localparam int SYNC = 2;
    localparam int DEB  = 16;
    localparam int DLY  = 2000;
    localparam int RATE = 400;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn, rpt_en, level, press, release_pulse, rpt;
    logic         any_press;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn), .rpt_en(rpt_en),
        .level(level), .press(press), .release_pulse(release_pulse),
        .rpt(rpt), .any_press(any_press)
    );

    // Reference model state
    logic [SYNC-1:0] m_sh [N];
    int              m_run [N];
    bit              m_level [N];
    longint          m_pedge [N];
    longint          edge_n = 0;
    logic [N-1:0]    e_level, e_press, e_rel, e_rpt;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_step();
        bit     s, was, rel_now;
        longint k;
        edge_n++;
        e_press = '0;
        e_rel   = '0;
        e_rpt   = '0;
        for (int ch = 0; ch < N; ch++) begin
            if (rst) begin
                m_sh[ch]    = '0;
                m_run[ch]   = 0;
                m_level[ch] = 1'b0;
            end else begin
                s        = m_sh[ch][SYNC-1];
                m_sh[ch] = {m_sh[ch][SYNC-2:0], btn[ch]};
                was      = m_level[ch];
                rel_now  = 1'b0;
                if (s != was) m_run[ch]++;
                else          m_run[ch] = 0;
                if (m_run[ch] == DEB + 1) begin
                    m_run[ch]   = 0;
                    m_level[ch] = !was;
                    if (!was) begin
                        e_press[ch] = 1'b1;
                        m_pedge[ch] = edge_n;
                    end else begin
                        e_rel[ch] = 1'b1;
                        rel_now   = 1'b1;
                    end
                end
                if (was && !rel_now) begin
                    k = edge_n - m_pedge[ch];
                    if (k >= DLY && ((k - DLY) % RATE) == 0 && rpt_en[ch])
                        e_rpt[ch] = 1'b1;
                end
            end
            e_level[ch] = m_level[ch];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("level", level, e_level);
        chk("press", press, e_press);
        chk("release", release_pulse, e_rel);
        chk("rpt", rpt, e_rpt);
        chk("any_press", any_press, |e_press);
    endtask

    task automatic idle(input int n);
        btn = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    int p_at, r_at, f_at, lvl_cnt, rpt_cnt, rel_cnt, prs_cnt, any_cnt;
    bit hold [N];
    int glitch [N];

    initial begin
        rst    = 1'b1;
        btn    = '0;
        rpt_en = '1;
        for (int i = 0; i < 3; i++) tick();
        chk("reset_outputs", {level, press, release_pulse, rpt}, 32'd0);
        rst = 1'b0;
        idle(10);

        // Short hold: press/release latency, no repeat
        p_at = -1; r_at = -1; lvl_cnt = 0; rpt_cnt = 0;
        for (int i = 0; i < 500; i++) begin
            btn[0] = (i < 400);
            tick();
            if (press[0]) p_at = i;
            if (release_pulse[0]) r_at = i;
            if (level[0]) lvl_cnt++;
            if (rpt[0]) rpt_cnt++;
        end
        chk("hold400_press_at", p_at, 18);
        chk("hold400_release_at", r_at, 418);
        chk("hold400_level_len", lvl_cnt, 400);
        chk("hold400_rpt_cnt", rpt_cnt, 0);
        idle(50);

        // Long hold with repeat; release edge coincides with a repeat slot
        f_at = -1; rpt_cnt = 0; r_at = -1;
        for (int i = 0; i < 4100; i++) begin
            btn[2] = (i < 4000);
            tick();
            if (rpt[2]) begin
                rpt_cnt++;
                if (f_at < 0) f_at = i;
            end
            if (release_pulse[2]) r_at = i;
        end
        chk("hold4000_rpt_cnt", rpt_cnt, 5);
        chk("hold4000_first_rpt", f_at, 18 + 2000);
        chk("hold4000_release_at", r_at, 4018);
        idle(50);

        // Glitch train
        prs_cnt = 0; lvl_cnt = 0;
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 20; i++) begin
                btn[3] = (i < 10);
                tick();
                if (press[3]) prs_cnt++;
                if (level[3]) lvl_cnt++;
            end
        end
        chk("glitch_press_cnt", prs_cnt, 0);
        chk("glitch_level_cnt", lvl_cnt, 0);
        idle(50);

        // Repeat enable gap suppresses one pulse without shifting cadence
        rpt_cnt = 0; f_at = -1;
        for (int i = 0; i < 4100; i++) begin
            btn[2]    = (i < 4000);
            rpt_en[2] = !(i >= 18 + 2100 && i < 18 + 2500);
            tick();
            if (rpt[2]) rpt_cnt++;
            if (rpt[2] && i > 18 + 2500 && f_at < 0) f_at = i;
        end
        rpt_en = '1;
        chk("gap_rpt_cnt", rpt_cnt, 3 + 1);
        chk("gap_resume_at", f_at, 18 + 2800);
        idle(50);

        // Reset during a hold: no release, re-detect afterwards
        rel_cnt = 0; p_at = -1;
        for (int i = 0; i < 1400; i++) begin
            btn[1] = (i < 1300);
            rst    = (i == 1018);
            tick();
            if (i == 1018) chk("midreset_level", level, 32'd0);
            if (release_pulse[1] && i < 1300) rel_cnt++;
            if (press[1] && i > 1018) p_at = i;
        end
        rst = 1'b0;
        chk("midreset_release_cnt", rel_cnt, 0);
        chk("midreset_repress_at", p_at, 1018 + 1 + 18);
        idle(50);

        // Simultaneous presses on two channels
        any_cnt = 0; p_at = -1;
        for (int i = 0; i < 100; i++) begin
            btn[0] = (i < 60);
            btn[4] = (i < 60);
            tick();
            if (any_press) begin
                any_cnt++;
                p_at = i;
            end
            if (i == 18) chk("dual_press_vec", press, 32'b10001);
        end
        chk("dual_any_cnt", any_cnt, 1);
        chk("dual_any_at", p_at, 18);
        idle(50);

        // Random stimulus
        for (int ch = 0; ch < N; ch++) begin
            hold[ch]   = 1'b0;
            glitch[ch] = 0;
        end
        for (int c = 0; c < 20000; c++) begin
            rst = ($urandom_range(4999, 0) == 0);
            if ($urandom_range(199, 0) == 0) rpt_en = N'($urandom);
            for (int ch = 0; ch < N; ch++) begin
                if ($urandom_range(1199, 0) == 0) hold[ch] = !hold[ch];
                if (glitch[ch] == 0 && $urandom_range(299, 0) == 0)
                    glitch[ch] = $urandom_range(20, 1);
                btn[ch] = hold[ch] ^ (glitch[ch] > 0);
                if (glitch[ch] > 0) glitch[ch]--;
            end
            tick();
        end
        rst = 1'b0;
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
